// File: rtl/uart_pkg.sv
// Shared UART-side constants: default receive word width and FIFO depth.
package uart_pkg;

  localparam int WIDTH_DATA_DEF = 8;
  localparam int DEPTH_LOG2_DEF = 4;
  localparam int PTR_W          = DEPTH_LOG2_DEF;

endpackage

// File: rtl/fifo_mem.sv
// Register file for rx_fifo: one synchronous write port, one asynchronous read port.
module fifo_mem
  import uart_pkg::*;
#(
  parameter int WIDTH_DATA = WIDTH_DATA_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [WIDTH_DATA-1:0] i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [WIDTH_DATA-1:0] o_rdata
);

  logic [WIDTH_DATA-1:0] mem [2**DEPTH_LOG2];

  // Storage is intentionally not reset; occupancy is tracked by the pointers.
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/rx_fifo.sv
// Show-ahead receive FIFO behind the UART receiver with a one-cycle acknowledge.
// Define RX_FIFO_OVR_EN to add the sticky overflow flag (i_ovr_clr / o_ovr).
module rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH_DATA = WIDTH_DATA_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_rdy,
  input  logic [WIDTH_DATA-1:0] i_data,
  output logic                  o_re,
  input  logic                  i_rd,
  output logic [WIDTH_DATA-1:0] o_data,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_count
`ifdef RX_FIFO_OVR_EN
  ,
  input  logic                  i_ovr_clr,
  output logic                  o_ovr
`endif
);

  localparam logic [DEPTH_LOG2:0] DEPTH = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);

  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  re_q;
  logic                  cap;
  logic                  pop;
  logic                  wr;

  // Handshake: i_rdy is a level held by the receiver until it sees o_re.
  // o_re is a registered one-cycle pulse; while it is high i_rdy is masked,
  // so a word is captured exactly once even if i_rdy is still high.
  assign cap = i_rdy && !re_q;
  assign pop = i_rd && !o_empty;
  assign wr  = cap && (!o_full || pop);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      re_q  <= 1'b0;
    end else begin
      re_q <= cap;
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  fifo_mem #(
    .WIDTH_DATA (WIDTH_DATA),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (wr),
    .i_waddr (wptr),
    .i_wdata (i_data),
    .i_raddr (rptr),
    .o_rdata (o_data)
  );

  assign o_re    = re_q;
  assign o_count = count;
  assign o_empty = (count == '0);
  assign o_full  = (count == DEPTH);

`ifdef RX_FIFO_OVR_EN
  logic drop;
  assign drop = cap && o_full && !pop;

  // Set wins over clear so an overflow in the clearing cycle is not lost.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)        o_ovr <= 1'b0;
    else if (drop)      o_ovr <= 1'b1;
    else if (i_ovr_clr) o_ovr <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_rx_fifo.sv
// Directed self-checking bench for rx_fifo (default build or RX_FIFO_OVR_EN).
module tb_rx_fifo;

  logic       clk;
  logic       nrst;
  logic       rdy;
  logic [7:0] din;
  logic       re;
  logic       rd;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       ovr_clr;
  logic       ovr;

  int test_cnt = 0;
  int fail_cnt = 0;
  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rx_fifo #(.WIDTH_DATA(8), .DEPTH_LOG2(4)) dut (
    .i_clk   (clk),
    .i_nrst  (nrst),
    .i_rdy   (rdy),
    .i_data  (din),
    .o_re    (re),
    .i_rd    (rd),
    .o_data  (dout),
    .o_empty (empty),
    .o_full  (full),
    .o_count (count)
`ifdef RX_FIFO_OVR_EN
    ,
    .i_ovr_clr (ovr_clr),
    .o_ovr     (ovr)
`endif
  );

`ifndef RX_FIFO_OVR_EN
  assign ovr = 1'b0;
`endif

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Receiver model: hold i_rdy until o_re is seen, then drop it.
  task automatic send_word(input logic [7:0] d, output bit got);
    rdy = 1'b1;
    din = d;
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      tick();
      if (re === 1'b1) got = 1'b1;
    end
    rdy = 1'b0;
    tick();
  endtask

  task automatic pop_word(output logic [7:0] d);
    d  = dout;
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    nrst = 1'b0; rdy = 1'b0; din = '0; rd = 1'b0; ovr_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_cnt++; if (empty !== 1'b1)   begin fail_cnt++; $display("FAIL reset_empty got=%b exp=1", empty); end
    test_cnt++; if (full !== 1'b0)    begin fail_cnt++; $display("FAIL reset_full got=%b exp=0", full); end
    test_cnt++; if (count !== 5'd0)   begin fail_cnt++; $display("FAIL reset_count got=%0d exp=0", count); end
    test_cnt++; if (re !== 1'b0)      begin fail_cnt++; $display("FAIL reset_re got=%b exp=0", re); end
    test_cnt++; if (ovr !== 1'b0)     begin fail_cnt++; $display("FAIL reset_ovr got=%b exp=0", ovr); end
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_single_capture();
    logic [7:0] d;
    rdy = 1'b1; din = 8'hA5;
    tick();
    test_cnt++; if (re !== 1'b1)      begin fail_cnt++; $display("FAIL single_re_hi got=%b exp=1", re); end
    test_cnt++; if (count !== 5'd1)   begin fail_cnt++; $display("FAIL single_count got=%0d exp=1", count); end
    test_cnt++; if (empty !== 1'b0)   begin fail_cnt++; $display("FAIL single_empty got=%b exp=0", empty); end
    test_cnt++; if (dout !== 8'hA5)   begin fail_cnt++; $display("FAIL single_data got=%h exp=a5", dout); end
    rdy = 1'b0;
    tick();
    test_cnt++; if (re !== 1'b0)      begin fail_cnt++; $display("FAIL single_re_lo got=%b exp=0", re); end
    test_cnt++; if (count !== 5'd1)   begin fail_cnt++; $display("FAIL single_count2 got=%0d exp=1", count); end
    pop_word(d);
    test_cnt++; if (d !== 8'hA5)      begin fail_cnt++; $display("FAIL single_pop got=%h exp=a5", d); end
    test_cnt++; if (empty !== 1'b1)   begin fail_cnt++; $display("FAIL single_empty2 got=%b exp=1", empty); end
  endtask

  task automatic test_set_wins();
    logic [7:0] d;
    rdy = 1'b1; din = 8'h11;
    tick();
    test_cnt++; if (re !== 1'b1)      begin fail_cnt++; $display("FAIL setwins_re1 got=%b exp=1", re); end
    din = 8'h3C;  // receiver reloads in the same cycle it consumes o_re
    tick();
    test_cnt++; if (re !== 1'b0)      begin fail_cnt++; $display("FAIL setwins_mask got=%b exp=0", re); end
    test_cnt++; if (count !== 5'd1)   begin fail_cnt++; $display("FAIL setwins_count1 got=%0d exp=1", count); end
    tick();
    test_cnt++; if (re !== 1'b1)      begin fail_cnt++; $display("FAIL setwins_re2 got=%b exp=1", re); end
    test_cnt++; if (count !== 5'd2)   begin fail_cnt++; $display("FAIL setwins_count2 got=%0d exp=2", count); end
    rdy = 1'b0;
    tick();
    test_cnt++; if (re !== 1'b0)      begin fail_cnt++; $display("FAIL setwins_re_end got=%b exp=0", re); end
    test_cnt++; if (count !== 5'd2)   begin fail_cnt++; $display("FAIL setwins_count3 got=%0d exp=2", count); end
    pop_word(d);
    test_cnt++; if (d !== 8'h11)      begin fail_cnt++; $display("FAIL setwins_pop1 got=%h exp=11", d); end
    pop_word(d);
    test_cnt++; if (d !== 8'h3C)      begin fail_cnt++; $display("FAIL setwins_pop2 got=%h exp=3c", d); end
    test_cnt++; if (empty !== 1'b1)   begin fail_cnt++; $display("FAIL setwins_empty got=%b exp=1", empty); end
  endtask

  task automatic test_overflow();
    bit got;
    for (int i = 0; i < 16; i++) begin
      send_word(8'(i), got);
      exp_q.push_back(8'(i));
      test_cnt++; if (got !== 1'b1)   begin fail_cnt++; $display("FAIL fill_re_timeout word=%0d", i); end
    end
    test_cnt++; if (full !== 1'b1)    begin fail_cnt++; $display("FAIL fill_full got=%b exp=1", full); end
    test_cnt++; if (count !== 5'd16)  begin fail_cnt++; $display("FAIL fill_count got=%0d exp=16", count); end
    test_cnt++; if (ovr !== 1'b0)     begin fail_cnt++; $display("FAIL fill_ovr got=%b exp=0", ovr); end
    send_word(8'hFF, got);
    test_cnt++; if (got !== 1'b1)     begin fail_cnt++; $display("FAIL ovf_re got=%b exp=1", got); end
    test_cnt++; if (count !== 5'd16)  begin fail_cnt++; $display("FAIL ovf_count got=%0d exp=16", count); end
    test_cnt++; if (dout !== 8'h00)   begin fail_cnt++; $display("FAIL ovf_head got=%h exp=00", dout); end
`ifdef RX_FIFO_OVR_EN
    test_cnt++; if (ovr !== 1'b1)     begin fail_cnt++; $display("FAIL ovf_flag got=%b exp=1", ovr); end
    tick();
    test_cnt++; if (ovr !== 1'b1)     begin fail_cnt++; $display("FAIL ovf_sticky got=%b exp=1", ovr); end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    test_cnt++; if (ovr !== 1'b0)     begin fail_cnt++; $display("FAIL ovf_clear got=%b exp=0", ovr); end
`endif
  endtask

  task automatic test_full_push_pop();
    logic [7:0] d;
    logic [7:0] e;
    rdy = 1'b1; din = 8'h77; rd = 1'b1;
    tick();
    rd = 1'b0; rdy = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h77);
    test_cnt++; if (re !== 1'b1)      begin fail_cnt++; $display("FAIL fpp_re got=%b exp=1", re); end
    test_cnt++; if (dout !== 8'h01)   begin fail_cnt++; $display("FAIL fpp_head got=%h exp=01", dout); end
    test_cnt++; if (count !== 5'd16)  begin fail_cnt++; $display("FAIL fpp_count got=%0d exp=16", count); end
    test_cnt++; if (full !== 1'b1)    begin fail_cnt++; $display("FAIL fpp_full got=%b exp=1", full); end
    test_cnt++; if (ovr !== 1'b0)     begin fail_cnt++; $display("FAIL fpp_ovr got=%b exp=0", ovr); end
    tick();
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      pop_word(d);
      test_cnt++; if (d !== e)        begin fail_cnt++; $display("FAIL fpp_drain idx=%0d got=%h exp=%h", i, d, e); end
    end
    test_cnt++; if (empty !== 1'b1)   begin fail_cnt++; $display("FAIL fpp_empty got=%b exp=1", empty); end
  endtask

  task automatic test_read_empty();
    logic [7:0] d;
    bit got;
    rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      test_cnt++; if (count !== 5'd0) begin fail_cnt++; $display("FAIL rdempty_count cyc=%0d got=%0d exp=0", i, count); end
      test_cnt++; if (empty !== 1'b1) begin fail_cnt++; $display("FAIL rdempty_empty cyc=%0d got=%b exp=1", i, empty); end
    end
    rd = 1'b0;
    send_word(8'h5A, got);
    test_cnt++; if (dout !== 8'h5A)   begin fail_cnt++; $display("FAIL rdempty_head got=%h exp=5a", dout); end
    test_cnt++; if (count !== 5'd1)   begin fail_cnt++; $display("FAIL rdempty_count1 got=%0d exp=1", count); end
    pop_word(d);
    test_cnt++; if (d !== 8'h5A)      begin fail_cnt++; $display("FAIL rdempty_pop got=%h exp=5a", d); end
    test_cnt++; if (empty !== 1'b1)   begin fail_cnt++; $display("FAIL rdempty_after got=%b exp=1", empty); end
  endtask

  task automatic test_wrap_and_reset();
    logic [7:0] d;
    logic [7:0] e;
    bit got;
    exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      send_word(8'h80 + 8'(i), got);
      exp_q.push_back(8'h80 + 8'(i));
      if (i % 2 == 1) begin
        e = exp_q.pop_front();
        pop_word(d);
        test_cnt++; if (d !== e)      begin fail_cnt++; $display("FAIL wrap_pop i=%0d got=%h exp=%h", i, d, e); end
      end
    end
    test_cnt++; if (count !== 5'd10)  begin fail_cnt++; $display("FAIL wrap_count got=%0d exp=10", count); end
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      pop_word(d);
      test_cnt++; if (d !== e)        begin fail_cnt++; $display("FAIL wrap_drain i=%0d got=%h exp=%h", i, d, e); end
    end
    test_cnt++; if (count !== 5'd5)   begin fail_cnt++; $display("FAIL wrap_count5 got=%0d exp=5", count); end
    // capture one more so an acknowledge is in flight, then reset mid-cycle
    rdy = 1'b1; din = 8'hEE;
    tick();
    test_cnt++; if (re !== 1'b1)      begin fail_cnt++; $display("FAIL midrst_re_pre got=%b exp=1", re); end
    #2 nrst = 1'b0;
    #1;
    test_cnt++; if (re !== 1'b0)      begin fail_cnt++; $display("FAIL midrst_re got=%b exp=0", re); end
    test_cnt++; if (empty !== 1'b1)   begin fail_cnt++; $display("FAIL midrst_empty got=%b exp=1", empty); end
    test_cnt++; if (count !== 5'd0)   begin fail_cnt++; $display("FAIL midrst_count got=%0d exp=0", count); end
    test_cnt++; if (full !== 1'b0)    begin fail_cnt++; $display("FAIL midrst_full got=%b exp=0", full); end
    rdy = 1'b0;
    exp_q.delete();
    @(negedge clk);
    nrst = 1'b1;
    tick();
    test_cnt++; if (empty !== 1'b1)   begin fail_cnt++; $display("FAIL postrst_empty got=%b exp=1", empty); end
    send_word(8'h42, got);
    test_cnt++; if (dout !== 8'h42)   begin fail_cnt++; $display("FAIL postrst_head got=%h exp=42", dout); end
    test_cnt++; if (count !== 5'd1)   begin fail_cnt++; $display("FAIL postrst_count got=%0d exp=1", count); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_capture();
    test_set_wins();
    test_overflow();
    test_full_push_pop();
    test_read_empty();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
